// File: rtl/mult_parity_core_pkg.sv
// Shared types and widths for the parity-checked iterative signed multiplier.
package mult_pkg;

   localparam int unsigned OP_W  = 16;
   localparam int unsigned RES_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACK,
      ST_CALC,
      ST_DONE
   } state_t;

   // Magnitude of a two's-complement operand; -32768 maps to 0x8000 unsigned.
   function automatic logic [OP_W-1:0] op_mag(input logic [OP_W-1:0] v);
      return v[OP_W-1] ? ((~v) + OP_W'(1)) : v;
   endfunction

endpackage

// File: rtl/mult_parity_core_if.sv
// Request/result bundle between a requester (master) and mult_parity_core (slave).
interface mult_parity_core_if;

   logic                      req;
   logic                      ack;
   logic [mult_pkg::OP_W-1:0] arg_a;
   logic                      arg_a_parity;
   logic [mult_pkg::OP_W-1:0] arg_b;
   logic                      arg_b_parity;
   logic [mult_pkg::RES_W-1:0] result;
   logic                      result_parity;
   logic                      result_rdy;
   logic                      arg_parity_error;

   modport master (
      output req, arg_a, arg_a_parity, arg_b, arg_b_parity,
      input  ack, result, result_parity, result_rdy, arg_parity_error
   );

   modport slave (
      input  req, arg_a, arg_a_parity, arg_b, arg_b_parity,
      output ack, result, result_parity, result_rdy, arg_parity_error
   );

endinterface

// File: rtl/mult_iter_dp.sv
// Sign-magnitude shift-add datapath retiring BITS_PER_CYCLE multiplier bits per step.
import mult_pkg::*;

module mult_iter_dp #(
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic [OP_W-1:0]  a_in,
   input  logic [OP_W-1:0]  b_in,
   output logic             last,
   output logic [RES_W-1:0] prod_final
);

   localparam int unsigned N = OP_W / BITS_PER_CYCLE;

   logic [RES_W-1:0] acc;
   logic [RES_W-1:0] acc_nxt;
   logic [RES_W-1:0] mcand;
   logic [OP_W-1:0]  mplier;
   logic             neg;
   logic [3:0]       cnt;

   always_comb begin
      acc_nxt = acc;
      for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
         if (mplier[j]) acc_nxt = acc_nxt + (mcand << j);
      end
   end

   // Includes the in-flight step so the product is ready on the final CALC edge.
   assign prod_final = neg ? (RES_W'(0) - acc_nxt) : acc_nxt;
   assign last       = (cnt == 4'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         neg    <= 1'b0;
         cnt    <= '0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= {{(RES_W-OP_W){1'b0}}, op_mag(a_in)};
         mplier <= op_mag(b_in);
         neg    <= a_in[OP_W-1] ^ b_in[OP_W-1];
         cnt    <= '0;
      end else if (step) begin
         acc    <= acc_nxt;
         mcand  <= mcand << BITS_PER_CYCLE;
         mplier <= mplier >> BITS_PER_CYCLE;
         cnt    <= cnt + 4'd1;
      end
   end

endmodule

// File: rtl/mult_parity_core.sv
// Request/ack front end with operand parity check around an iterative signed multiplier.
import mult_pkg::*;

module mult_parity_core #(
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   mult_parity_core_if.slave  bus
);

   state_t           state;
   logic             armed;
   logic             ack_q;
   logic             rdy_q;
   logic             perr_q;
   logic             rpar_q;
   logic [RES_W-1:0] res_q;
   logic [OP_W-1:0]  cap_a;
   logic [OP_W-1:0]  cap_b;
   logic             cap_pa;
   logic             cap_pb;

   logic             bad_par;
   logic             dp_load;
   logic             dp_step;
   logic             dp_last;
   logic [RES_W-1:0] dp_prod;

   assign bad_par = ((^cap_a) != cap_pa) || ((^cap_b) != cap_pb);
   assign dp_load = (state == ST_ACK) && !bad_par;
   assign dp_step = (state == ST_CALC);

   mult_iter_dp #(
      .BITS_PER_CYCLE(BITS_PER_CYCLE)
   ) u_dp (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (dp_load),
      .step       (dp_step),
      .a_in       (cap_a),
      .b_in       (cap_b),
      .last       (dp_last),
      .prod_final (dp_prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         armed  <= 1'b1;
         ack_q  <= 1'b0;
         rdy_q  <= 1'b0;
         perr_q <= 1'b0;
         rpar_q <= 1'b0;
         res_q  <= '0;
         cap_a  <= '0;
         cap_b  <= '0;
         cap_pa <= 1'b0;
         cap_pb <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         rdy_q <= 1'b0;
         // A request held high past its ack must drop before it can start another op.
         if (!bus.req) armed <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (bus.req && armed) begin
                  cap_a  <= bus.arg_a;
                  cap_b  <= bus.arg_b;
                  cap_pa <= bus.arg_a_parity;
                  cap_pb <= bus.arg_b_parity;
                  armed  <= 1'b0;
                  ack_q  <= 1'b1;
                  state  <= ST_ACK;
               end
            end
            ST_ACK: begin
               if (bad_par) begin
                  res_q  <= '0;
                  rpar_q <= 1'b0;
                  perr_q <= 1'b1;
                  rdy_q  <= 1'b1;
                  state  <= ST_DONE;
               end else begin
                  state  <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (dp_last) begin
                  res_q  <= dp_prod;
                  rpar_q <= ^dp_prod;
                  perr_q <= 1'b0;
                  rdy_q  <= 1'b1;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.ack              = ack_q;
   assign bus.result_rdy       = rdy_q;
   assign bus.result           = res_q;
   assign bus.result_parity    = rpar_q;
   assign bus.arg_parity_error = perr_q;

endmodule

// File: tb/tb_mult_parity_core.sv
// Directed bench for mult_parity_core at BITS_PER_CYCLE 1 and 4.
module tb_mult_parity_core;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mult_parity_core_if bus1 ();
   mult_parity_core_if bus4 ();

   mult_parity_core #(.BITS_PER_CYCLE(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   mult_parity_core #(.BITS_PER_CYCLE(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   // sel chooses which instance the op task drives and observes
   logic        sel = 1'b0;
   logic        ack_s, rdy_s, rpar_s, perr_s;
   logic [31:0] res_s;

   assign ack_s  = sel ? bus4.ack              : bus1.ack;
   assign rdy_s  = sel ? bus4.result_rdy       : bus1.result_rdy;
   assign rpar_s = sel ? bus4.result_parity    : bus1.result_parity;
   assign perr_s = sel ? bus4.arg_parity_error : bus1.arg_parity_error;
   assign res_s  = sel ? bus4.result           : bus1.result;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic pa, input logic pb);
      if (s) begin
         bus4.arg_a = a; bus4.arg_b = b; bus4.arg_a_parity = pa; bus4.arg_b_parity = pb;
      end else begin
         bus1.arg_a = a; bus1.arg_b = b; bus1.arg_a_parity = pa; bus1.arg_b_parity = pb;
      end
   endtask

   task automatic set_req(input logic s, input logic r);
      if (s) bus4.req = r;
      else   bus1.req = r;
   endtask

   // Latency is the cycle index T0+k in which result_rdy is seen, edge 0 being acceptance.
   task automatic op(input string tag, input logic s, input logic [15:0] a, input logic [15:0] b,
                     input logic pa, input logic pb, input int hold, input int exp_lat,
                     input logic [31:0] exp_res, input logic exp_rp, input logic exp_err);
      int          lat;
      int          n_ack;
      int          n_rdy;
      int          both;
      logic [31:0] r;
      logic        rp;
      logic        pe;
      sel = s;
      lat = -1; n_rdy = 0; both = 0; r = '0; rp = 1'b0; pe = 1'b0;
      @(negedge clk);
      drive(s, a, b, pa, pb);
      set_req(s, 1'b1);
      @(posedge clk); #1;
      check({tag, "_ack_t1"}, 32'(ack_s), 32'd1);
      n_ack = ack_s ? 1 : 0;
      drive(s, ~a, a ^ 16'h5a5a, ~pa, pb);
      for (int e = 1; e <= 45; e++) begin
         if (e > hold) set_req(s, 1'b0);
         @(posedge clk); #1;
         if (ack_s) n_ack++;
         if (ack_s && rdy_s) both++;
         if (rdy_s) begin
            n_rdy++;
            if (lat < 0) begin
               lat = e + 1;
               r   = res_s;
               rp  = rpar_s;
               pe  = perr_s;
            end
         end
      end
      check({tag, "_lat"},    32'(lat),   32'(exp_lat));
      check({tag, "_n_ack"},  32'(n_ack), 32'd1);
      check({tag, "_n_rdy"},  32'(n_rdy), 32'd1);
      check({tag, "_excl"},   32'(both),  32'd0);
      check({tag, "_result"}, r,          exp_res);
      check({tag, "_rpar"},   32'(rp),    32'(exp_rp));
      check({tag, "_perr"},   32'(pe),    32'(exp_err));
      check({tag, "_hold"},   res_s,      exp_res);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int n_rdy;
      rst_n = 1'b0;
      bus1.req = 1'b0; bus4.req = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      drive(1'b1, '0, '0, 1'b0, 1'b0);
      #3;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check("rst_ack",  32'(ack_s),  32'd0);
         check("rst_rdy",  32'(rdy_s),  32'd0);
         check("rst_res",  res_s,       32'd0);
         check("rst_rpar", 32'(rpar_s), 32'd0);
         check("rst_perr", 32'(perr_s), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      op("mul3xm5",  1'b0, 16'd3,   16'hFFFB, ^16'd3,   ^16'hFFFB, 0, 18, 32'hFFFFFFF1, 1'b1, 1'b0);
      op("minxmin",  1'b0, 16'h8000, 16'h8000, 1'b1,    1'b1,      0, 18, 32'h40000000, 1'b1, 1'b0);
      op("bad_pa",   1'b0, 16'h0001, 16'h0002, 1'b0,    1'b1,      0, 2,  32'h00000000, 1'b0, 1'b1);
      op("m7x6",     1'b0, 16'hFFF9, 16'd6,   ^16'hFFF9, ^16'd6,   0, 18, 32'hFFFFFFD6, 1'b1, 1'b0);

      // Abort mid-CALC: accept, then reset in CALC cycle 5.
      sel = 1'b0;
      @(negedge clk);
      drive(1'b0, 16'd7, 16'd9, ^16'd7, ^16'd9);
      set_req(1'b0, 1'b1);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_res",  res_s,       32'd0);
      check("abort_rpar", 32'(rpar_s), 32'd0);
      check("abort_rdy",  32'(rdy_s),  32'd0);
      check("abort_ack",  32'(ack_s),  32'd0);
      #1 rst_n = 1'b1;
      n_rdy = 0;
      for (int e = 0; e < 25; e++) begin
         @(posedge clk); #1;
         if (rdy_s) n_rdy++;
      end
      check("abort_no_rdy", 32'(n_rdy), 32'd0);

      op("post2x2",  1'b0, 16'd2,   16'd2,   ^16'd2,   ^16'd2,   0,  18, 32'h00000004, 1'b1, 1'b0);
      op("hold40",   1'b0, 16'd1,   16'd1,   1'b1,     1'b1,     40, 18, 32'h00000001, 1'b1, 1'b0);

      op("b4_max",   1'b1, 16'h7FFF, 16'hFFFF, 1'b1,   1'b0,     0, 6,  32'hFFFF8001, 1'b0, 1'b0);
      op("b4_3xm5",  1'b1, 16'd3,   16'hFFFB, ^16'd3,   ^16'hFFFB, 0, 6,  32'hFFFFFFF1, 1'b1, 1'b0);
      op("b4_bad_pb", 1'b1, 16'd5,  16'd3,   ^16'd5,   1'b1,      0, 2,  32'h00000000, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
